// File: rtl/branch_stack.sv
// branch_stack: checkpoint stack for in-flight conditional branches.
// Each dispatched branch saves a free-list snapshot and ROB tail in a ring
// of DEPTH entries. On a correct resolve the entry is released. On a
// misprediction the snapshot is driven out in the same cycle, and that
// entry plus every younger entry is squashed.
// Optional feature macro: BSTACK_SAME_CYCLE_FREE_EN. When it is defined,
// a full stack accepts a dispatch in a cycle that frees a slot.

`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module branch_stack #(
    parameter int DEPTH        = 8,
    parameter int PHYS_REGS    = `PHYS_REG_SZ_R10K,
    parameter int ROB_IDX_BITS = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      branch_valid,
    input  logic [PHYS_REGS-1:0]      branch_free_list,
    input  logic [ROB_IDX_BITS-1:0]   branch_rob_tail,
    output logic                      branch_ready,
    output logic [$clog2(DEPTH)-1:0]  branch_tag,
    input  logic                      resolve_valid,
    input  logic [$clog2(DEPTH)-1:0]  resolve_tag,
    input  logic                      resolve_mispredict,
    output logic                      restore_flag,
    output logic [PHYS_REGS-1:0]      free_list_restore,
    output logic [ROB_IDX_BITS-1:0]   rob_tail_restore,
    output logic [DEPTH-1:0]          squash_mask,
    output logic [DEPTH-1:0]          live_mask
);

    localparam int TW = $clog2(DEPTH);
    localparam int CW = TW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [PHYS_REGS-1:0]    fl_q [DEPTH];
    logic [ROB_IDX_BITS-1:0] rt_q [DEPTH];
    logic [TW-1:0]           head_q, head_d;
    logic [TW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;

    logic                    tag_live_s;
    logic                    mp_s;
    logic                    cr_s;
    logic                    ready_s;
    logic                    alloc_s;
    logic [CW-1:0]           span_s;
    logic [TW-1:0]           off_s;
    logic [DEPTH-1:0]        squash_s;
    logic [CW-1:0]           adv_s;
    logic                    scan_s;
    logic [TW-1:0]           idx_s;

    assign tag_live_s = valid_q[resolve_tag];
    assign mp_s       = resolve_valid && resolve_mispredict && tag_live_s;
    assign cr_s       = resolve_valid && !resolve_mispredict && tag_live_s;

`ifdef BSTACK_SAME_CYCLE_FREE_EN
    // Full stack still accepts when this cycle frees the head or rewinds the tail.
    assign ready_s = (count_q < FULL_CNT) || (cr_s && (resolve_tag == head_q)) || mp_s;
`else
    assign ready_s = (count_q < FULL_CNT);
`endif

    // A mispredict always squashes the branch dispatching alongside it.
    assign alloc_s = branch_valid && ready_s && !mp_s;

    // Squash window: resolve_tag up to tail-1, wrapping; a zero distance means the whole ring.
    always_comb begin
        squash_s = '0;
        off_s    = '0;
        span_s   = {1'b0, TW'(tail_q - resolve_tag)};
        if (span_s == '0) begin
            span_s = FULL_CNT;
        end else begin
            span_s = span_s;
        end
        for (int i = 0; i < DEPTH; i++) begin
            off_s = TW'(i) - resolve_tag;
            if (mp_s && ({1'b0, off_s} < span_s)) begin
                squash_s[i] = 1'b1;
            end else begin
                squash_s[i] = 1'b0;
            end
        end
    end

    // Next-state: rewind on mispredict, otherwise release, retire from head, then allocate.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        adv_s   = '0;
        scan_s  = 1'b1;
        idx_s   = '0;
        if (mp_s) begin
            valid_d = valid_q & ~squash_s;
            tail_d  = resolve_tag;
            count_d = {1'b0, TW'(resolve_tag - head_q)};
        end else begin
            if (cr_s) begin
                valid_d[resolve_tag] = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            // Retire every contiguous released entry starting at head.
            for (int k = 0; k < DEPTH; k++) begin
                idx_s = head_q + TW'(k);
                if (scan_s && (CW'(k) < count_q) && !valid_d[idx_s]) begin
                    adv_s = adv_s + CW'(1);
                end else begin
                    scan_s = 1'b0;
                end
            end
            head_d = head_q + adv_s[TW-1:0];
            if (alloc_s) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + TW'(1);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q - adv_s + {{TW{1'b0}}, alloc_s};
        end
    end

    // Control state: valid bits and ring pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Snapshot storage, written only on allocation and otherwise never modified.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fl_q[i] <= '0;
                rt_q[i] <= '0;
            end
        end else if (alloc_s) begin
            fl_q[tail_q] <= branch_free_list;
            rt_q[tail_q] <= branch_rob_tail;
        end
    end

    assign branch_ready      = ready_s;
    assign branch_tag        = tail_q;
    assign restore_flag      = mp_s;
    assign free_list_restore = mp_s ? fl_q[resolve_tag] : '0;
    assign rob_tail_restore  = mp_s ? rt_q[resolve_tag] : '0;
    assign squash_mask       = squash_s;
    assign live_mask         = valid_q;

endmodule

// File: tb/tb_branch_stack.sv
// Testbench for branch_stack: directed vector table, hand sequence, and
// randomized traffic checked against an age-ordered queue model.
module tb_branch_stack;

    localparam int DEPTH = 8;
    localparam int PR    = 32;
    localparam int RB    = 5;
    localparam int TW    = 3;
`ifdef BSTACK_SAME_CYCLE_FREE_EN
    localparam bit SCF = 1'b1;
`else
    localparam bit SCF = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            branch_valid = 1'b0;
    logic [PR-1:0]   branch_free_list = '0;
    logic [RB-1:0]   branch_rob_tail = '0;
    logic            branch_ready;
    logic [TW-1:0]   branch_tag;
    logic            resolve_valid = 1'b0;
    logic [TW-1:0]   resolve_tag = '0;
    logic            resolve_mispredict = 1'b0;
    logic            restore_flag;
    logic [PR-1:0]   free_list_restore;
    logic [RB-1:0]   rob_tail_restore;
    logic [DEPTH-1:0] squash_mask;
    logic [DEPTH-1:0] live_mask;

    always #5 clock = ~clock;

    branch_stack #(.DEPTH(DEPTH), .PHYS_REGS(PR), .ROB_IDX_BITS(RB)) dut (
        .clock(clock), .reset(reset),
        .branch_valid(branch_valid), .branch_free_list(branch_free_list),
        .branch_rob_tail(branch_rob_tail), .branch_ready(branch_ready),
        .branch_tag(branch_tag), .resolve_valid(resolve_valid),
        .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
        .restore_flag(restore_flag), .free_list_restore(free_list_restore),
        .rob_tail_restore(rob_tail_restore), .squash_mask(squash_mask),
        .live_mask(live_mask)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: age-ordered queue of checkpoints ----------------
    int               q_tag[$];
    bit               q_live[$];
    int               m_tail;
    logic [PR-1:0]    m_fl[DEPTH];
    logic [RB-1:0]    m_rt[DEPTH];
    int               m_idx;
    bit               m_mp, m_cr, m_rdy;
    bit               cur_rst;

    task automatic model_reset();
        q_tag.delete();
        q_live.delete();
        m_tail = 0;
    endtask

    task automatic model_eval_check();
        logic [DEPTH-1:0] e_sq;
        logic [DEPTH-1:0] e_live;
        int e_head;
        m_idx = -1;
        if (resolve_valid)
            for (int i = 0; i < q_tag.size(); i++)
                if (q_tag[i] == int'(resolve_tag) && q_live[i]) m_idx = i;
        m_mp  = (m_idx >= 0) && resolve_mispredict;
        m_cr  = (m_idx >= 0) && !resolve_mispredict;
        m_rdy = q_tag.size() < DEPTH;
        if (SCF && ((m_cr && m_idx == 0) || m_mp)) m_rdy = 1'b1;
        e_sq = '0;
        if (m_mp)
            for (int i = m_idx; i < q_tag.size(); i++) e_sq[q_tag[i]] = 1'b1;
        e_live = '0;
        for (int i = 0; i < q_tag.size(); i++)
            if (q_live[i]) e_live[q_tag[i]] = 1'b1;
        e_head = (q_tag.size() > 0) ? q_tag[0] : m_tail;
        chk("m.ready", 64'(branch_ready), 64'(m_rdy));
        chk("m.tag", 64'(branch_tag), 64'(m_tail));
        chk("m.restore_flag", 64'(restore_flag), 64'(m_mp));
        chk("m.free_list_restore", 64'(free_list_restore), m_mp ? 64'(m_fl[resolve_tag]) : 64'(0));
        chk("m.rob_tail_restore", 64'(rob_tail_restore), m_mp ? 64'(m_rt[resolve_tag]) : 64'(0));
        chk("m.squash_mask", 64'(squash_mask), 64'(e_sq));
        chk("m.live_mask", 64'(live_mask), 64'(e_live));
        chk("m.head", 64'(dut.head_q), 64'(e_head));
        chk("m.count", 64'(dut.count_q), 64'(q_tag.size()));
    endtask

    task automatic model_update();
        if (m_mp) begin
            m_tail = int'(resolve_tag);
            while (q_tag.size() > m_idx) begin
                void'(q_tag.pop_back());
                void'(q_live.pop_back());
            end
        end else begin
            if (m_cr) q_live[m_idx] = 1'b0;
            while (q_tag.size() > 0 && !q_live[0]) begin
                void'(q_tag.pop_front());
                void'(q_live.pop_front());
            end
            if (branch_valid && m_rdy) begin
                m_fl[m_tail] = branch_free_list;
                m_rt[m_tail] = branch_rob_tail;
                q_tag.push_back(m_tail);
                q_live.push_back(1'b1);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    endtask

    task automatic drive(input bit rst, input bit bv, input logic [PR-1:0] fl, input logic [RB-1:0] rt,
                         input bit rv, input logic [TW-1:0] rtag, input bit rm);
        @(negedge clock);
        reset              = rst ? 1'b0 : 1'b1;
        branch_valid       = bv;
        branch_free_list   = fl;
        branch_rob_tail    = rt;
        resolve_valid      = rv;
        resolve_tag        = rtag;
        resolve_mispredict = rm;
        cur_rst            = rst;
        #1;
        if (rst) model_reset();
        model_eval_check();
    endtask

    task automatic commit();
        @(posedge clock);
        if (!cur_rst) model_update();
        #1;
    endtask

    task automatic cyc(input bit rst, input bit bv, input logic [PR-1:0] fl, input logic [RB-1:0] rt,
                       input bit rv, input logic [TW-1:0] rtag, input bit rm);
        drive(rst, bv, fl, rt, rv, rtag, rm);
        commit();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit bv; logic [PR-1:0] fl; logic [RB-1:0] rt;
        bit rv; logic [TW-1:0] rtag; bit rm;
        bit e_rdy; logic [TW-1:0] e_tag; bit e_rf; logic [PR-1:0] e_flr;
        logic [RB-1:0] e_rtr; logic [DEPTH-1:0] e_sq; logic [DEPTH-1:0] e_live;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rst, input bit bv, input logic [PR-1:0] fl, input logic [RB-1:0] rt,
                       input bit rv, input logic [TW-1:0] rtag, input bit rm,
                       input bit e_rdy, input logic [TW-1:0] e_tag, input bit e_rf, input logic [PR-1:0] e_flr,
                       input logic [RB-1:0] e_rtr, input logic [DEPTH-1:0] e_sq, input logic [DEPTH-1:0] e_live);
        vec_t v;
        v.rst = rst; v.bv = bv; v.fl = fl; v.rt = rt; v.rv = rv; v.rtag = rtag; v.rm = rm;
        v.e_rdy = e_rdy; v.e_tag = e_tag; v.e_rf = e_rf; v.e_flr = e_flr;
        v.e_rtr = e_rtr; v.e_sq = e_sq; v.e_live = e_live;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset, three allocations, then two more and a mispredict of tag 1.
        add(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0,  1'b1, 3'd0, 1'b0, 32'h0, 5'd0, 8'h00, 8'h00);
        add(1'b0, 1'b1, 32'h1000, 5'd3, 1'b0, 3'd0, 1'b0,  1'b1, 3'd0, 1'b0, 32'h0, 5'd0, 8'h00, 8'h00);
        add(1'b0, 1'b1, 32'h0000_F0F0, 5'd4, 1'b0, 3'd0, 1'b0,  1'b1, 3'd1, 1'b0, 32'h0, 5'd0, 8'h00, 8'h01);
        add(1'b0, 1'b1, 32'h1002, 5'd5, 1'b0, 3'd0, 1'b0,  1'b1, 3'd2, 1'b0, 32'h0, 5'd0, 8'h00, 8'h03);
        add(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0,  1'b1, 3'd3, 1'b0, 32'h0, 5'd0, 8'h00, 8'h07);
        add(1'b0, 1'b1, 32'h1003, 5'd6, 1'b0, 3'd0, 1'b0,  1'b1, 3'd3, 1'b0, 32'h0, 5'd0, 8'h00, 8'h07);
        add(1'b0, 1'b1, 32'h1004, 5'd7, 1'b0, 3'd0, 1'b0,  1'b1, 3'd4, 1'b0, 32'h0, 5'd0, 8'h00, 8'h0F);
        add(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 3'd1, 1'b1,  1'b1, 3'd5, 1'b1, 32'h0000_F0F0, 5'd4, 8'h1E, 8'h1F);
        add(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0,  1'b1, 3'd1, 1'b0, 32'h0, 5'd0, 8'h00, 8'h01);
        // Fill to eight, then a dispatch against a full stack.
        for (int i = 1; i < 8; i++)
            add(1'b0, 1'b1, 32'h2000 + PR'(i), RB'(i), 1'b0, 3'd0, 1'b0,
                1'b1, TW'(i), 1'b0, 32'h0, 5'd0, 8'h00, DEPTH'((1 << i) - 1));
        add(1'b0, 1'b1, 32'hDEAD, 5'd9, 1'b0, 3'd0, 1'b0,  1'b0, 3'd0, 1'b0, 32'h0, 5'd0, 8'h00, 8'hFF);
        add(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0,  1'b0, 3'd0, 1'b0, 32'h0, 5'd0, 8'h00, 8'hFF);
        // Full, correct resolve of head together with a dispatch.
        add(1'b0, 1'b1, 32'hABCD, 5'd9, 1'b1, 3'd0, 1'b0,  SCF, 3'd0, 1'b0, 32'h0, 5'd0, 8'h00, 8'hFF);
        add(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0,  !SCF, SCF ? 3'd1 : 3'd0, 1'b0, 32'h0, 5'd0, 8'h00,
            SCF ? 8'hFF : 8'hFE);
        // Wrap: walk head to 6, then live 6,7,0,1 and mispredict 7 with a dispatch.
        add(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0,  1'b1, 3'd0, 1'b0, 32'h0, 5'd0, 8'h00, 8'h00);
        add(1'b0, 1'b1, 32'h40, 5'd0, 1'b0, 3'd0, 1'b0,  1'b1, 3'd0, 1'b0, 32'h0, 5'd0, 8'h00, 8'h00);
        for (int k = 1; k < 6; k++)
            add(1'b0, 1'b1, 32'h40 + PR'(k), RB'(k), 1'b1, TW'(k - 1), 1'b0,
                1'b1, TW'(k), 1'b0, 32'h0, 5'd0, 8'h00, DEPTH'(1 << (k - 1)));
        add(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 3'd5, 1'b0,  1'b1, 3'd6, 1'b0, 32'h0, 5'd0, 8'h00, 8'h20);
        add(1'b0, 1'b1, 32'h66, 5'd6, 1'b0, 3'd0, 1'b0,  1'b1, 3'd6, 1'b0, 32'h0, 5'd0, 8'h00, 8'h00);
        add(1'b0, 1'b1, 32'h77, 5'd7, 1'b0, 3'd0, 1'b0,  1'b1, 3'd7, 1'b0, 32'h0, 5'd0, 8'h00, 8'h40);
        add(1'b0, 1'b1, 32'h80, 5'd8, 1'b0, 3'd0, 1'b0,  1'b1, 3'd0, 1'b0, 32'h0, 5'd0, 8'h00, 8'hC0);
        add(1'b0, 1'b1, 32'h81, 5'd9, 1'b0, 3'd0, 1'b0,  1'b1, 3'd1, 1'b0, 32'h0, 5'd0, 8'h00, 8'hC1);
        add(1'b0, 1'b1, 32'h99, 5'd1, 1'b1, 3'd7, 1'b1,  1'b1, 3'd2, 1'b1, 32'h77, 5'd7, 8'h83, 8'hC3);
        add(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0,  1'b1, 3'd7, 1'b0, 32'h0, 5'd0, 8'h00, 8'h40);
        // Resolve on a tag that is not live is ignored.
        add(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 3'd3, 1'b1,  1'b1, 3'd7, 1'b0, 32'h0, 5'd0, 8'h00, 8'h40);
        add(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0,  1'b1, 3'd7, 1'b0, 32'h0, 5'd0, 8'h00, 8'h40);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].bv, tbl[i].fl, tbl[i].rt, tbl[i].rv, tbl[i].rtag, tbl[i].rm);
            chk($sformatf("v%0d.ready", i), 64'(branch_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("v%0d.tag", i), 64'(branch_tag), 64'(tbl[i].e_tag));
            chk($sformatf("v%0d.restore_flag", i), 64'(restore_flag), 64'(tbl[i].e_rf));
            chk($sformatf("v%0d.free_list_restore", i), 64'(free_list_restore), 64'(tbl[i].e_flr));
            chk($sformatf("v%0d.rob_tail_restore", i), 64'(rob_tail_restore), 64'(tbl[i].e_rtr));
            chk($sformatf("v%0d.squash_mask", i), 64'(squash_mask), 64'(tbl[i].e_sq));
            chk($sformatf("v%0d.live_mask", i), 64'(live_mask), 64'(tbl[i].e_live));
            commit();
        end

        // Hand sequence: out-of-order correct resolves and head advance.
        cyc(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h300 + PR'(i), RB'(i), 1'b0, 3'd0, 1'b0);
        chk("seq.count4", 64'(dut.count_q), 64'd4);
        cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 3'd2, 1'b0);
        chk("seq.head_after_2", 64'(dut.head_q), 64'd0);
        cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 3'd0, 1'b0);
        chk("seq.head_after_0", 64'(dut.head_q), 64'd1);
        chk("seq.live_after_0", 64'(live_mask), 64'h0A);
        cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 3'd1, 1'b0);
        chk("seq.head_after_1", 64'(dut.head_q), 64'd3);
        chk("seq.count_after_1", 64'(dut.count_q), 64'd1);

        // Randomized traffic with phases that favour filling or draining.
        for (int c = 0; c < 3000; c++) begin
            bit bv, rv, rm, rst;
            logic [TW-1:0] rtag;
            int phase;
            phase = (c / 200) % 3;
            rst   = ($urandom_range(399, 0) == 0);
            bv    = (phase == 1) ? ($urandom_range(9, 0) != 0) : ($urandom_range(1, 0) == 1);
            rv    = (phase == 1) ? ($urandom_range(4, 0) == 0) : ($urandom_range(2, 0) != 0);
            rm    = ($urandom_range(3, 0) == 0);
            if (q_tag.size() > 0 && $urandom_range(3, 0) != 0)
                rtag = TW'(q_tag[$urandom_range(q_tag.size() - 1, 0)]);
            else
                rtag = TW'($urandom_range(DEPTH - 1, 0));
            cyc(rst, bv, PR'($urandom), RB'($urandom), rv, rtag, rm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
